// File: rtl/aclk_time_counter_pkg.sv
// Shared definitions for the alarm-clock time path: BCD digit sizes, digit
// maxima and the {ms_hour, ls_hour, ms_min, ls_min} field layout.
package aclk_defs;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned TIME_W  = 16;

    localparam logic [DIGIT_W-1:0] MIN_LS_MAX      = 4'd9;
    localparam logic [DIGIT_W-1:0] MIN_MS_MAX      = 4'd5;
    localparam logic [DIGIT_W-1:0] HR_LS_MAX       = 4'd9;
    localparam logic [DIGIT_W-1:0] HR_MS_MAX       = 4'd2;
    localparam logic [DIGIT_W-1:0] HR_LS_MAX_AT_20 = 4'd3;

    // Field LSB positions within the packed time vector
    localparam int unsigned LS_MIN_LSB  = 0;
    localparam int unsigned MS_MIN_LSB  = 4;
    localparam int unsigned LS_HOUR_LSB = 8;
    localparam int unsigned MS_HOUR_LSB = 12;

    typedef struct packed {
        logic [DIGIT_W-1:0] ms_hour;
        logic [DIGIT_W-1:0] ls_hour;
        logic [DIGIT_W-1:0] ms_min;
        logic [DIGIT_W-1:0] ls_min;
    } bcd_time_t;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic ok;
        ok = (t.ls_min  <= MIN_LS_MAX) &&
             (t.ms_min  <= MIN_MS_MAX) &&
             (t.ls_hour <= HR_LS_MAX)  &&
             (t.ms_hour <= HR_MS_MAX);
        if (t.ms_hour == HR_MS_MAX && t.ls_hour > HR_LS_MAX_AT_20)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/aclk_time_counter_digit.sv
// One BCD counter digit with synchronous load and wrap-at-maximum carry.
module aclk_bcd_digit
    import aclk_defs::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [DIGIT_W-1:0] wrap_at,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry_out
);

    logic wrap_due;

    // ">=" rather than "==" so an out-of-range digit recovers on its next step
    assign wrap_due  = (digit >= wrap_at);
    assign carry_out = en && wrap_due;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            digit <= '0;
        else if (load)
            digit <= load_val;
        else if (en)
            digit <= wrap_due ? '0 : digit + 1'b1;
    end

endmodule

// File: rtl/aclk_time_counter.sv
// 24-hour BCD time-of-day counter: minute advance, validated load, wrap strobes.
module aclk_time_counter
    import aclk_defs::*;
#(
    parameter bit LOAD_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              one_minute,
    input  logic              load_new_c,
    input  logic [TIME_W-1:0] new_current_time,
    output logic [TIME_W-1:0] current_time,
    output logic              hour_tick,
    output logic              day_wrap,
    output logic              load_err
);

    bcd_time_t new_t;
    bcd_time_t cur_t;

    logic load_valid;
    logic load_ok;
    logic inc_en;
    logic c_ls_min, c_ms_min, c_ls_hour, c_ms_hour;
    logic hour_due;
    logic hour_wrap;
    logic hour_load;
    logic [DIGIT_W-1:0] ls_hour_load_val;
    logic [DIGIT_W-1:0] ms_hour_load_val;

    assign new_t = bcd_time_t'(new_current_time);

    always_comb begin
        load_valid = 1'b1;
        if (LOAD_CHECK)
            load_valid = bcd_time_valid(new_t);
    end

    always_comb begin
        load_ok = load_new_c && load_valid;
        // A rejected load does not swallow the strobe
        inc_en  = one_minute && !load_ok;
    end

    always_comb begin
        hour_due = (cur_t.ms_hour > HR_MS_MAX) ||
                   ((cur_t.ms_hour == HR_MS_MAX) && (cur_t.ls_hour >= HR_LS_MAX_AT_20));
        hour_wrap = c_ms_min && hour_due;
        hour_load = load_ok || hour_wrap;
        ls_hour_load_val = load_ok ? new_t.ls_hour : '0;
        ms_hour_load_val = load_ok ? new_t.ms_hour : '0;
    end

    aclk_bcd_digit u_ls_min (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (inc_en),
        .wrap_at   (MIN_LS_MAX),
        .load      (load_ok),
        .load_val  (new_t.ls_min),
        .digit     (cur_t.ls_min),
        .carry_out (c_ls_min)
    );

    aclk_bcd_digit u_ms_min (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (c_ls_min),
        .wrap_at   (MIN_MS_MAX),
        .load      (load_ok),
        .load_val  (new_t.ms_min),
        .digit     (cur_t.ms_min),
        .carry_out (c_ms_min)
    );

    // Hour digits reuse the load path to clear on the 23 -> 00 wrap
    aclk_bcd_digit u_ls_hour (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (c_ms_min),
        .wrap_at   (HR_LS_MAX),
        .load      (hour_load),
        .load_val  (ls_hour_load_val),
        .digit     (cur_t.ls_hour),
        .carry_out (c_ls_hour)
    );

    aclk_bcd_digit u_ms_hour (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (c_ls_hour),
        .wrap_at   (HR_MS_MAX),
        .load      (hour_load),
        .load_val  (ms_hour_load_val),
        .digit     (cur_t.ms_hour),
        .carry_out (c_ms_hour)
    );

    assign current_time = TIME_W'(cur_t);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hour_tick <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            hour_tick <= c_ms_min;
            day_wrap  <= hour_wrap;
            load_err  <= load_new_c && !load_valid;
        end
    end

endmodule

// File: tb/tb_aclk_time_counter.sv
// Directed self-checking bench for aclk_time_counter.
module tb_aclk_time_counter;

    logic        clk;
    logic        reset_n;
    logic        one_minute;
    logic        load_new_c;
    logic [15:0] new_current_time;
    logic [15:0] current_time;
    logic        hour_tick;
    logic        day_wrap;
    logic        load_err;

    int unsigned errors;
    int unsigned checks;
    int unsigned ht_count;
    int unsigned dw_count;

    aclk_time_counter #(.LOAD_CHECK(1'b1)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .one_minute       (one_minute),
        .load_new_c       (load_new_c),
        .new_current_time (new_current_time),
        .current_time     (current_time),
        .hour_tick        (hour_tick),
        .day_wrap         (day_wrap),
        .load_err         (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] t,
                             input logic ht, input logic dw, input logic le);
        check({tag, ".time"}, current_time, t);
        check({tag, ".hour_tick"}, {15'd0, hour_tick}, {15'd0, ht});
        check({tag, ".day_wrap"}, {15'd0, day_wrap}, {15'd0, dw});
        check({tag, ".load_err"}, {15'd0, load_err}, {15'd0, le});
    endtask

    // Apply inputs after a falling edge, then sample 1 ns past the rising edge.
    task automatic step(input logic ld, input logic [15:0] val, input logic om);
        @(negedge clk);
        load_new_c       = ld;
        new_current_time = val;
        one_minute       = om;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        one_minute = 1'b0;
        load_new_c = 1'b0;
        new_current_time = 16'h0000;

        // Reset held while strobes keep arriving
        #1;
        one_minute = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        one_minute = 1'b0;
        reset_n = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        check_out("post_reset_idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("first_inc", 16'h0001, 1'b0, 1'b0, 1'b0);

        // Hour rollover
        step(1'b1, 16'h0959, 1'b0);
        check_out("load_0959", 16'h0959, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("roll_1000", 16'h1000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        check_out("roll_1000_after", 16'h1000, 1'b0, 1'b0, 1'b0);

        // Day wrap
        step(1'b1, 16'h2359, 1'b0);
        check_out("load_2359", 16'h2359, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("day_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        check_out("day_wrap_after", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1959, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("roll_2000", 16'h2000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h1259, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("roll_1300", 16'h1300, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("inc_1301", 16'h1301, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0709, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("carry_0710", 16'h0710, 1'b0, 1'b0, 1'b0);

        // Load validation from a known 0710
        step(1'b1, 16'h2400, 1'b0);
        check_out("rej_2400", 16'h0710, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0960, 1'b0);
        check_out("rej_0960", 16'h0710, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0A00, 1'b0);
        check_out("rej_0A00", 16'h0710, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h3000, 1'b0);
        check_out("rej_3000", 16'h0710, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h000A, 1'b0);
        check_out("rej_000A", 16'h0710, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h2359, 1'b0);
        check_out("acc_2359", 16'h2359, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1959, 1'b0);
        check_out("acc_1959", 16'h1959, 1'b0, 1'b0, 1'b0);

        // Simultaneous load and strobe
        step(1'b1, 16'h1234, 1'b0);
        step(1'b1, 16'h0800, 1'b1);
        check_out("sim_valid", 16'h0800, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        step(1'b1, 16'h0060, 1'b1);
        check_out("sim_invalid", 16'h1235, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0959, 1'b0);
        step(1'b1, 16'h2500, 1'b1);
        check_out("sim_invalid_roll", 16'h1000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        check_out("sim_after", 16'h1000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset clears a pending strobe immediately
        step(1'b1, 16'h2359, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        check_out("pre_async", 16'h0000, 1'b1, 1'b1, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        one_minute = 1'b0;
        reset_n = 1'b1;

        // Full day of back-to-back strobes
        step(1'b1, 16'h0000, 1'b0);
        ht_count = 0;
        dw_count = 0;
        for (int i = 0; i < 1440; i++) begin
            step(1'b0, 16'h0000, 1'b1);
            if (hour_tick) ht_count++;
            if (day_wrap)  dw_count++;
            if (i == 59)  check("fast_0100", current_time, 16'h0100);
            if (i == 779) check("fast_1300", current_time, 16'h1300);
        end
        check("fast_end_time", current_time, 16'h0000);
        check("fast_hour_ticks", 16'(ht_count), 16'd24);
        check("fast_day_wraps", 16'(dw_count), 16'd1);

        // Spaced strobes across the last two hours of the day
        step(1'b1, 16'h2200, 1'b0);
        ht_count = 0;
        dw_count = 0;
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 16'h0000, 1'b1);
            if (hour_tick) ht_count++;
            if (day_wrap)  dw_count++;
            for (int j = 0; j < 255; j++) begin
                step(1'b0, 16'h0000, 1'b0);
                if (hour_tick) ht_count++;
                if (day_wrap)  dw_count++;
            end
            if (i == 59) check("slow_2300", current_time, 16'h2300);
        end
        check("slow_end_time", current_time, 16'h0000);
        check("slow_hour_ticks", 16'(ht_count), 16'd2);
        check("slow_day_wraps", 16'(dw_count), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
